// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter one frame at a time.
// Launches on trmt, waits for tx_done, optionally idles GAP_CYCLES between frames.
module uart_tx_queue #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_ovf,
    input  logic                     tx_done,
    output logic                     trmt,
    output logic [7:0]               tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic            trmt_q, trmt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            ovf_q, ovf_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            full_w, empty_w;
    logic            push, pop, drop;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Launch sequencer: pops only from IDLE, then ignores the stale done for one cycle
    always_comb begin
        state_d   = state_q;
        trmt_d    = 1'b0;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    pop       = 1'b1;
                    trmt_d    = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GW'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop on the same edge frees room for a push into a full queue
    always_comb begin
        push     = wr_en && (!full_w || pop);
        drop     = wr_en && !push;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and datapath registers; reset abandons queue and in-flight byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            trmt_q    <= 1'b0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
            gap_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            trmt_q    <= trmt_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
            gap_q     <= gap_d;
            mem_q     <= mem_d;
        end
    end

    assign trmt     = trmt_q;
    assign tx_data  = tx_data_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: two instances (no gap / 3-cycle gap) against a timestamp model.
// Launched bytes go to a scoreboard that a negedge monitor drains on trmt.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic [1:0] tx_done = 2'b11;

    logic [1:0] trmt_v;
    logic [1:0] full_v;
    logic [1:0] empty_v;
    logic [1:0] busy_v;
    logic [1:0] ovf_v;
    logic [7:0] txd_v [2];
    logic [3:0] cnt_v [2];

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .tx_done(tx_done[0]), .trmt(trmt_v[0]),
        .tx_data(txd_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .count(cnt_v[0]), .busy(busy_v[0]), .overflow(ovf_v[0])
    );

    uart_tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(3)) u_gap (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .tx_done(tx_done[1]), .trmt(trmt_v[1]),
        .tx_data(txd_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .count(cnt_v[1]), .busy(busy_v[1]), .overflow(ovf_v[1])
    );

    typedef logic [7:0] bq_t [$];

    bq_t        mq [2];
    bq_t        sb [2];
    bit         m_inf [2];
    longint     m_free [2];
    longint     m_launch [2];
    bit         m_trmt [2];
    bit         m_ovf [2];
    logic [7:0] m_last [2];
    int         gapc [2] = '{0, 3};
    longint     cyc = 0;
    bit         stale [2];
    int         tcnt [2];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: launch allowed when nothing in flight and gap expired
    task automatic step(input int i);
        bit         pop;
        bit         drop;
        logic [7:0] b;
        if (rst) begin
            mq[i].delete();
            m_inf[i]  = 0;
            m_free[i] = 0;
            m_trmt[i] = 0;
            m_ovf[i]  = 0;
            m_last[i] = 8'h00;
            return;
        end
        pop = !m_inf[i] && (cyc >= m_free[i]) && (mq[i].size() > 0);
        if (m_inf[i] && cyc >= m_launch[i] + 2 && tx_done[i]) begin
            m_inf[i]  = 0;
            m_free[i] = cyc + 1 + gapc[i];
        end
        m_trmt[i] = 0;
        if (pop) begin
            b = mq[i].pop_front();
            m_last[i]   = b;
            sb[i].push_back(b);
            m_inf[i]    = 1;
            m_launch[i] = cyc;
            m_trmt[i]   = 1;
        end
        drop = 0;
        if (wr_en) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(wr_data);
            else drop = 1;
        end
        if (drop) m_ovf[i] = 1;
        else if (clr_ovf) m_ovf[i] = 0;
    endtask

    // Advance the model on every edge using the inputs held since the negedge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) step(i);
        cyc++;
    end

    // Transmitter stand-in: drops done on launch, raises it some cycles later
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stale[i]) begin
                tx_done[i] = 1'b1;
            end else if (trmt_v[i] === 1'b1) begin
                tx_done[i] = 1'b0;
                tcnt[i]    = $urandom_range(1, 8);
            end else if (tcnt[i] > 0) begin
                tcnt[i]--;
                if (tcnt[i] == 0) tx_done[i] = 1'b1;
            end
        end
    end

    // Monitor: per-cycle status against model, tx_data against scoreboard on trmt
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("count%0d", i), 32'(cnt_v[i]), 32'(mq[i].size()));
                chk($sformatf("empty%0d", i), 32'(empty_v[i]), 32'(mq[i].size() == 0));
                chk($sformatf("full%0d", i), 32'(full_v[i]), 32'(mq[i].size() == DEPTH));
                chk($sformatf("busy%0d", i), 32'(busy_v[i]),
                    32'(m_inf[i] || cyc < m_free[i]));
                chk($sformatf("overflow%0d", i), 32'(ovf_v[i]), 32'(m_ovf[i]));
                chk($sformatf("trmt%0d", i), 32'(trmt_v[i]), 32'(m_trmt[i]));
                chk($sformatf("tx_data_hold%0d", i), 32'(txd_v[i]), 32'(m_last[i]));
                if (trmt_v[i] === 1'b1) begin
                    if (sb[i].size() == 0) begin
                        chk($sformatf("unexpected_trmt%0d", i), 32'(txd_v[i]), 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("launch_byte%0d", i), 32'(txd_v[i]),
                            32'(sb[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    function automatic bit drained();
        for (int i = 0; i < 2; i++) begin
            if (mq[i].size() != 0 || m_inf[i] || cyc < m_free[i]) return 0;
        end
        return 1;
    endfunction

    task automatic drain();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (drained()) return;
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int dens;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        push_byte(8'hA5);
        repeat (20) @(negedge clk);

        for (int b = 1; b <= 10; b++) push_byte(8'(b));
        drain();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        push_byte(8'h11);
        push_byte(8'h22);
        drain();

        stale[0] = 1;
        stale[1] = 1;
        push_byte(8'h3C);
        repeat (12) @(negedge clk);
        stale[0] = 0;
        stale[1] = 0;
        drain();

        for (int b = 0; b < 4; b++) push_byte(8'hC0 + 8'(b));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        dens = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) dens = $urandom_range(5, 95);
            wr_en   = ($urandom_range(0, 99) < dens);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        rst     = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        chk("sb_empty0", 32'(sb[0].size()), 32'd0);
        chk("sb_empty1", 32'(sb[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
